// File: rtl/sub_top_sys_sdram_pll_seq_pkg.sv
// Shared definitions for the system/SDRAM PLL power-up sequencer:
// FSM state encoding, default parameter values and a counter-width helper.
package pll_seq_pkg;

    // Sequencer states; explicit encodings keep the state register stable across builds.
    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } pll_seq_state_t;

    localparam int DEF_PLL_RST_CYCLES = 16;
    localparam int DEF_LOCK_TIMEOUT   = 65536;
    localparam int DEF_STABLE_CYCLES  = 1024;
    localparam int DEF_MAX_RETRIES    = 3;

    // Width of a counter that must hold values up to (terminal - 1) without wrapping.
    function automatic int cnt_width(input int terminal);
        return $clog2(terminal) + 1;
    endfunction

endpackage

// File: rtl/sub_top_sys_sdram_pll_seq_sync_2ff.sv
// Two-flop synchronizer bringing the asynchronous PLL lock indication into
// the reference clock domain. Both flops clear on the synchronous reset so a
// stale lock cannot survive a sequencer restart.
module sync_2ff (
    input  logic refclk,
    input  logic rst,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    // Capture the asynchronous input, then re-register to resolve metastability.
    always_ff @(posedge refclk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/sub_top_sys_sdram_pll_seq.sv
// Power-up and lock-loss sequencer for the system/SDRAM PLL.
// Drives the PLL reset, qualifies the synchronized lock for a stable window,
// then releases the downstream reset. A bounded number of attempts is made
// before the sticky fail flag is raised; only rst leaves the FAIL state.
// Optional build macro PLL_SEQ_STATUS_EN exposes retry_cnt and a saturating
// lock_loss_cnt; the FSM behaves identically with or without it.
module sub_top_sys_sdram_pll_seq
    import pll_seq_pkg::*;
#(
    parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
    parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int MAX_RETRIES    = DEF_MAX_RETRIES
) (
    input  logic refclk,
    input  logic rst,
    input  logic locked,
    output logic pll_rst,
    output logic sys_rst,
    output logic ready,
    output logic fail
`ifdef PLL_SEQ_STATUS_EN
    ,
    output logic [$clog2(MAX_RETRIES+1)-1:0] retry_cnt,
    output logic [7:0]                        lock_loss_cnt
`endif
);

    localparam int RST_W = cnt_width(PLL_RST_CYCLES);
    localparam int TO_W  = cnt_width(LOCK_TIMEOUT);
    localparam int STB_W = cnt_width(STABLE_CYCLES);
    localparam int RTY_W = $clog2(MAX_RETRIES + 1);

    localparam logic [RST_W-1:0] RST_LAST = RST_W'(PLL_RST_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT - 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);

    pll_seq_state_t   state_q, state_d;
    logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [STB_W-1:0] stb_cnt_q, stb_cnt_d;
    logic [RTY_W-1:0] rty_cnt_q, rty_cnt_d;

    logic pll_rst_q;
    logic sys_rst_q;
    logic ready_q;
    logic fail_q;

    logic             lock_s;
    logic             timeout_s;
    logic [TO_W-1:0]  to_inc_s;
    logic [RTY_W-1:0] rty_next_s;

    sync_2ff u_lock_sync (
        .refclk  (refclk),
        .rst     (rst),
        .async_i (locked),
        .sync_o  (lock_s)
    );

    // The timeout counter holds at its terminal value: if lock wins the race
    // in WAIT_LOCK on that very cycle, the timeout still fires from STABLE.
    assign timeout_s  = (to_cnt_q == TO_LAST);
    assign to_inc_s   = timeout_s ? to_cnt_q : (to_cnt_q + 1'b1);
    assign rty_next_s = rty_cnt_q + 1'b1;

    // Next-state and counter logic; counters default to zero so each one
    // starts cleared whenever its state is (re)entered.
    always_comb begin
        state_d   = state_q;
        rst_cnt_d = '0;
        to_cnt_d  = '0;
        stb_cnt_d = '0;
        rty_cnt_d = rty_cnt_q;
        case (state_q)
            ST_PLL_RST: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            ST_WAIT_LOCK: begin
                to_cnt_d = to_inc_s;
                if (lock_s) begin
                    state_d = ST_STABLE;
                end else if (timeout_s) begin
                    to_cnt_d  = '0;
                    rty_cnt_d = rty_next_s;
                    if (rty_next_s == RTY_MAX) begin
                        state_d = ST_FAIL;
                    end else begin
                        state_d = ST_PLL_RST;
                    end
                end else begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            ST_STABLE: begin
                to_cnt_d = to_inc_s;
                if (timeout_s) begin
                    // Timeout takes priority over a simultaneous lock drop.
                    to_cnt_d  = '0;
                    rty_cnt_d = rty_next_s;
                    if (rty_next_s == RTY_MAX) begin
                        state_d = ST_FAIL;
                    end else begin
                        state_d = ST_PLL_RST;
                    end
                end else if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (stb_cnt_q == STB_LAST) begin
                    state_d   = ST_RUN;
                    rty_cnt_d = '0;
                end else begin
                    stb_cnt_d = stb_cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                rty_cnt_d = '0;
                if (!lock_s) begin
                    state_d = ST_PLL_RST;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_PLL_RST;
            end
        endcase
    end

    // State, counters and outputs; outputs decode the next state so they
    // change on the same edge as the state register.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q   <= ST_PLL_RST;
            rst_cnt_q <= '0;
            to_cnt_q  <= '0;
            stb_cnt_q <= '0;
            rty_cnt_q <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            to_cnt_q  <= to_cnt_d;
            stb_cnt_q <= stb_cnt_d;
            rty_cnt_q <= rty_cnt_d;
            pll_rst_q <= (state_d == ST_PLL_RST) || (state_d == ST_FAIL);
            sys_rst_q <= (state_d != ST_RUN);
            ready_q   <= (state_d == ST_RUN);
            fail_q    <= (state_d == ST_FAIL);
        end
    end

    assign pll_rst = pll_rst_q;
    assign sys_rst = sys_rst_q;
    assign ready   = ready_q;
    assign fail    = fail_q;

`ifdef PLL_SEQ_STATUS_EN
    logic       loss_evt_s;
    logic [7:0] lock_loss_q;

    assign loss_evt_s = (state_q == ST_RUN) && !lock_s;

    // Saturating count of lock losses observed while running.
    always_ff @(posedge refclk) begin
        if (rst) begin
            lock_loss_q <= 8'd0;
        end else if (loss_evt_s && (lock_loss_q != 8'hFF)) begin
            lock_loss_q <= lock_loss_q + 8'd1;
        end else begin
            lock_loss_q <= lock_loss_q;
        end
    end

    assign retry_cnt     = rty_cnt_q;
    assign lock_loss_cnt = lock_loss_q;
`endif

endmodule

// File: tb/tb_sub_top_sys_sdram_pll_seq.sv
// Scoreboard bench for the PLL sequencer. Stimulus pushes the expected edge
// number and value of every output-vector change {pll_rst,sys_rst,ready,fail},
// plus point probes; a monitor on the falling edge pops and compares.
module tb_sub_top_sys_sdram_pll_seq;

    logic clk = 1'b0;
    logic rst;
    logic locked;
    logic pll_rst, sys_rst, ready, fail;
`ifdef PLL_SEQ_STATUS_EN
    logic [1:0] retry_cnt;
    logic [7:0] lock_loss_cnt;
`endif

    sub_top_sys_sdram_pll_seq #(
        .PLL_RST_CYCLES (4),
        .LOCK_TIMEOUT   (32),
        .STABLE_CYCLES  (8),
        .MAX_RETRIES    (3)
    ) dut (
        .refclk  (clk),
        .rst     (rst),
        .locked  (locked),
        .pll_rst (pll_rst),
        .sys_rst (sys_rst),
        .ready   (ready),
        .fail    (fail)
`ifdef PLL_SEQ_STATUS_EN
        ,
        .retry_cnt     (retry_cnt),
        .lock_loss_cnt (lock_loss_cnt)
`endif
    );

    always #10 clk = ~clk;

    typedef struct {
        int         e;
        logic [3:0] v;
    } exp_t;

    typedef struct {
        int    e;
        int    kind;
        int    v;
        string nm;
    } probe_t;

    localparam int K_OUT   = 0;
    localparam int K_RETRY = 1;
    localparam int K_LOSS  = 2;

    exp_t   exp_q[$];
    probe_t probe_q[$];

    int edge_n = 0;
    int total  = 0;
    int bad    = 0;
    logic end_req = 1'b0;
    logic done    = 1'b0;
    logic [3:0] prev_out = 4'b1100;
    logic [3:0] cur;
    exp_t   ex;
    probe_t pr;
    int     got;
    int     b;

    always @(posedge clk) edge_n <= edge_n + 1;

    // Scoreboard monitor: every output change must match the next expectation.
    always @(negedge clk) begin
        if (edge_n >= 1) begin
            cur = {pll_rst, sys_rst, ready, fail};
            if (cur !== prev_out) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL out_change edge=%0d got=%b required=no change", edge_n, cur);
                end else begin
                    ex = exp_q.pop_front();
                    if ((ex.e != edge_n) || (ex.v !== cur)) begin
                        bad++;
                        $display("FAIL out_change edge=%0d got=%b required edge=%0d value=%b",
                                 edge_n, cur, ex.e, ex.v);
                    end
                end
                prev_out = cur;
            end
            while ((probe_q.size() > 0) && (probe_q[0].e <= edge_n)) begin
                pr = probe_q.pop_front();
                total++;
                case (pr.kind)
                    K_OUT:   got = int'({pll_rst, sys_rst, ready, fail});
`ifdef PLL_SEQ_STATUS_EN
                    K_RETRY: got = int'(retry_cnt);
                    K_LOSS:  got = int'(lock_loss_cnt);
`endif
                    default: got = -1;
                endcase
                if ((got != pr.v) || (pr.e != edge_n)) begin
                    bad++;
                    $display("FAIL %s edge=%0d got=%0d required=%0d at edge %0d",
                             pr.nm, edge_n, got, pr.v, pr.e);
                end
            end
            if (end_req && !done) begin
                total++;
                if ((exp_q.size() != 0) || (probe_q.size() != 0)) begin
                    bad++;
                    $display("FAIL pending_expectations got=%0d/%0d required=0/0",
                             exp_q.size(), probe_q.size());
                end
                done = 1'b1;
            end
        end
    end

    task automatic push_exp(input int e, input logic [3:0] v);
        exp_t t;
        t.e = e;
        t.v = v;
        exp_q.push_back(t);
    endtask

    task automatic push_probe(input int e, input int kind, input int v, input string nm);
        probe_t t;
        t.e    = e;
        t.kind = kind;
        t.v    = v;
        t.nm   = nm;
`ifdef PLL_SEQ_STATUS_EN
        probe_q.push_back(t);
`else
        if (kind == K_OUT) probe_q.push_back(t);
`endif
    endtask

    // Returns at the falling edge after rising edge number e.
    task automatic wait_edge(input int e);
        while (edge_n < e) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog edge=%0d required=finish", edge_n);
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        locked = 1'b0;
        push_probe(2, K_OUT,   4'b1100, "reset_out");
        push_probe(2, K_RETRY, 0,       "reset_retry");
        push_probe(2, K_LOSS,  0,       "reset_loss");
        wait_edge(3);

        // Clean bring-up: locked rises 10 cycles after release.
        rst = 1'b0;
        b   = edge_n;
        push_exp(b + 4, 4'b0100);
        wait_edge(b + 10);
        locked = 1'b1;
        push_exp(b + 21, 4'b0010);
        push_probe(b + 22, K_RETRY, 0, "run_retry");

        // Loss in RUN, one timed-out attempt, then re-lock.
        wait_edge(b + 25);
        locked = 1'b0;
        push_exp(b + 28, 4'b1100);
        push_probe(b + 29, K_LOSS, 1, "loss_cnt");
        push_exp(b + 32, 4'b0100);
        push_exp(b + 64, 4'b1100);
        push_exp(b + 68, 4'b0100);
        push_probe(b + 69, K_RETRY, 1, "retry_after_timeout");
        wait_edge(b + 70);
        locked = 1'b1;
        push_exp(b + 81, 4'b0010);
        push_probe(b + 82, K_RETRY, 0, "relock_retry");
        push_probe(b + 82, K_LOSS,  1, "relock_loss");

        // Lock never asserts: three attempts then FAIL at cycle 108.
        wait_edge(b + 85);
        locked = 1'b0;
        rst    = 1'b1;
        push_exp(b + 86, 4'b1100);
        wait_edge(b + 86);
        rst = 1'b0;
        b   = edge_n;
        push_exp(b + 4,   4'b0100);
        push_exp(b + 36,  4'b1100);
        push_exp(b + 40,  4'b0100);
        push_exp(b + 72,  4'b1100);
        push_exp(b + 76,  4'b0100);
        push_exp(b + 108, 4'b1101);
        push_probe(b + 109, K_RETRY, 3,       "fail_retry");
        push_probe(b + 120, K_OUT,   4'b1101, "fail_sticky");
        wait_edge(b + 120);

        // Reset during FAIL, then chattering lock (toggle every 5 cycles).
        rst = 1'b1;
        push_exp(b + 121, 4'b1100);
        push_probe(b + 121, K_RETRY, 0, "rst_fail_retry");
        push_probe(b + 121, K_LOSS,  0, "rst_fail_loss");
        wait_edge(b + 121);
        rst    = 1'b0;
        locked = 1'b1;
        b      = edge_n;
        push_exp(b + 4,   4'b0100);
        push_exp(b + 36,  4'b1100);
        push_exp(b + 40,  4'b0100);
        push_exp(b + 72,  4'b1100);
        push_exp(b + 76,  4'b0100);
        push_exp(b + 108, 4'b1101);
        push_probe(b + 109, K_RETRY, 3,       "chatter_retry");
        push_probe(b + 120, K_OUT,   4'b1101, "chatter_fail");
        for (int i = 0; i < 24; i++) begin
            wait_edge(b + 5 * (i + 1));
            locked = ~locked;
        end

        // Reset from FAIL with lock held, then reset again during STABLE.
        rst    = 1'b1;
        locked = 1'b1;
        push_exp(b + 121, 4'b1100);
        wait_edge(b + 121);
        rst = 1'b0;
        b   = edge_n;
        push_exp(b + 4, 4'b0100);
        wait_edge(b + 7);
        rst = 1'b1;
        push_exp(b + 8, 4'b1100);
        wait_edge(b + 8);
        rst = 1'b0;
        b   = edge_n;
        push_exp(b + 4,  4'b0100);
        push_exp(b + 13, 4'b0010);
        push_probe(b + 14, K_RETRY, 0, "final_retry");
        push_probe(b + 14, K_LOSS,  0, "final_loss");
        wait_edge(b + 16);

        end_req = 1'b1;
        wait (done);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
